// File: rtl/ysyx_22040931_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: opcode and FSM
// encodings plus the opcode classification helpers used by decode and FIX.
package ysyx_22040931_mdu_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam int WORD_W = 32;

    // Opcodes 13..15 are unused; they still run but return zero.
    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'd12);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        case (op)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Multiplies that return the upper half of the product.
    function automatic logic is_mulh(input logic [3:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // src1 is treated as a signed operand.
    function automatic logic is_signed(input logic [3:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
            OP_MULW, OP_DIVW, OP_REMW: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // src2 is signed for the same ops as src1, except MULHSU.
    function automatic logic is_signed2(input logic [3:0] op);
        return is_signed(op) && (op != OP_MULHSU);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd12);
    endfunction

endpackage

// File: rtl/ysyx_22040931_mdu_decode.sv
// Combinational op classification and operand preparation: narrows W ops to
// their low word (sign- or zero-extended), extracts signs and magnitudes.
module ysyx_22040931_mdu_decode
    import ysyx_22040931_mdu_pkg::*;
#(
    parameter int XLEN = 64
)(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            legal,
    output logic            div,
    output logic            word,
    output logic            s1_neg,
    output logic            s2_neg,
    output logic [XLEN-1:0] a_abs,
    output logic [XLEN-1:0] b_abs
);

    logic signed [WORD_W-1:0] lo1, lo2;
    logic        [XLEN-1:0]   ext1, ext2;

    // Classify the op, extend the operands to the op width, split sign/magnitude
    always_comb begin
        legal = is_legal(op);
        div   = is_div(op);
        word  = is_word(op);
        lo1   = src1[WORD_W-1:0];
        lo2   = src2[WORD_W-1:0];
        ext1  = src1;
        ext2  = src2;
        if (word) begin
            if (is_signed(op)) ext1 = XLEN'(lo1);
            else               ext1 = XLEN'(src1[WORD_W-1:0]);
            if (is_signed2(op)) ext2 = XLEN'(lo2);
            else                ext2 = XLEN'(src2[WORD_W-1:0]);
        end
        s1_neg = is_signed(op)  & ext1[XLEN-1];
        s2_neg = is_signed2(op) & ext2[XLEN-1];
        a_abs  = s1_neg ? -ext1 : ext1;
        b_abs  = s2_neg ? -ext2 : ext2;
    end

endmodule

// File: rtl/ysyx_22040931_mdu.sv
// Iterative radix-2 RV64M multiply/divide unit with valid/ready handshakes.
// Magnitudes are multiplied (shift-add) or divided (restoring) over N cycles,
// then signs are fixed up and the result half selected in one FIX cycle.
// Optional macro YSYX_22040931_MDU_SPECIAL_BYPASS_EN: divide-by-zero, signed
// overflow and multiply-by-zero skip CALC and go straight to FIX.
module ysyx_22040931_mdu
    import ysyx_22040931_mdu_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int CNT_W = $clog2(XLEN) + 1
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    mdu_state_e        state, state_nxt;
    logic [3:0]        op_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r;

    logic              d_legal, d_div, d_word, d_s1_neg, d_s2_neg;
    logic [XLEN-1:0]   d_a_abs, d_b_abs;
    logic              accept, bypass;
    logic [2*XLEN-1:0] bypass_acc, acc_step;
    logic [XLEN-1:0]   result;

    ysyx_22040931_mdu_decode #(.XLEN(XLEN)) u_decode (
        .op     (in_op),
        .src1   (in_src1),
        .src2   (in_src2),
        .legal  (d_legal),
        .div    (d_div),
        .word   (d_word),
        .s1_neg (d_s1_neg),
        .s2_neg (d_s2_neg),
        .a_abs  (d_a_abs),
        .b_abs  (d_b_abs)
    );

    assign accept = in_valid & in_ready & ~flush;

`ifdef YSYX_22040931_MDU_SPECIAL_BYPASS_EN
    logic            div_zero, div_ovf, mul_zero;
    logic [XLEN-1:0] min_mag;

    // Spot special cases at issue and preload the final magnitudes for FIX
    always_comb begin
        min_mag    = d_word ? (XLEN'(1) << (WORD_W - 1)) : (XLEN'(1) << (XLEN - 1));
        div_zero   = d_div & (d_b_abs == '0);
        div_ovf    = d_div & d_s1_neg & d_s2_neg & (d_a_abs == min_mag) & (d_b_abs == XLEN'(1));
        mul_zero   = d_legal & ~d_div & ((d_a_abs == '0) | (d_b_abs == '0));
        bypass     = div_zero | div_ovf | mul_zero;
        bypass_acc = '0;
        if (div_zero)     bypass_acc = {d_a_abs, {XLEN{1'b1}}};
        else if (div_ovf) bypass_acc = {{XLEN{1'b0}}, d_a_abs};
    end
`else
    assign bypass     = 1'b0;
    assign bypass_acc = '0;
`endif

    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_borrow;

    // One radix-2 step: shift-add multiply or restoring divide on acc
    always_comb begin
        mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        // A carried-out top bit means the partial remainder already exceeds any divisor.
        div_borrow = ~div_shift[XLEN] & (div_shift[XLEN-1:0] < opb);
        div_diff   = div_shift[XLEN-1:0] - opb;
        if (is_div(op_q))
            acc_step = {(div_borrow ? div_shift[XLEN-1:0] : div_diff), acc[XLEN-2:0], ~div_borrow};
        else
            acc_step = {mul_sum, acc[XLEN-1:1]};
    end

    logic        [2*XLEN-1:0] prod_mag, prod;
    logic        [XLEN-1:0]   quo, rem, res_raw;
    logic signed [WORD_W-1:0] res_w;

    // Sign fix-up, half/quotient/remainder select and W-op sign extension
    always_comb begin
        // A 32-step word multiply leaves its product 32 bits higher in acc.
        prod_mag = is_word(op_q) ? (acc >> (XLEN - WORD_W)) : acc;
        prod     = neg_q ? -prod_mag : prod_mag;
        quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res_raw  = '0;
        if (is_legal(op_q)) begin
            if (is_div(op_q)) res_raw = is_rem(op_q)  ? rem : quo;
            else              res_raw = is_mulh(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
        res_w  = res_raw[WORD_W-1:0];
        result = is_word(op_q) ? XLEN'(res_w) : res_raw;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; flush wins over everything
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = bypass ? FIX : CALC;
            end
            CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand latch at issue, iteration in CALC, result capture in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= in_op;
                    cnt   <= d_word ? CNT_W'(WORD_W) : CNT_W'(XLEN);
                    // A zero divisor must yield all ones, so its quotient is never negated.
                    neg_q <= (d_s1_neg ^ d_s2_neg) & ~(d_div & (d_b_abs == '0));
                    neg_r <= d_s1_neg;
                    if (d_div) begin
                        opb <= d_b_abs;
                        acc <= {{XLEN{1'b0}}, (d_word ? (d_a_abs << (XLEN - WORD_W)) : d_a_abs)};
                    end else begin
                        opb <= d_a_abs;
                        acc <= {{XLEN{1'b0}}, d_b_abs};
                    end
                    if (bypass) acc <= bypass_acc;
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX:     out_data <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_mdu.sv
// Self-checking bench for ysyx_22040931_mdu (XLEN=64): directed cases,
// flush/reset interruptions and random ops against an arithmetic model.
module tb_ysyx_22040931_mdu;
    import ysyx_22040931_mdu_pkg::*;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [63:0] in_src1, in_src2, out_data;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22040931_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

    // Architectural result of an M-extension op, straight from the ISA rules
    function automatic logic [63:0] ref_mdu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] xa, xb, ps;
        logic [127:0]        pu;
        logic signed [63:0]  sa, sb, sq;
        logic signed [31:0]  wa, wb, wq;
        logic [31:0]         ua, ub;
        logic [63:0]         r;
        sa = a; sb = b;
        wa = a[31:0]; wb = b[31:0];
        ua = a[31:0]; ub = b[31:0];
        xa = sa; xb = sb;
        r  = '0;
        case (op)
            4'd0: r = a * b;
            4'd1: begin ps = xa * xb; r = ps[127:64]; end
            4'd2: begin xb = {64'd0, b}; ps = xa * xb; r = ps[127:64]; end
            4'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
            4'd4: if (b == 0) r = '1;
                  else if (a == MIN64 && b == '1) r = MIN64;
                  else begin sq = sa / sb; r = sq; end
            4'd5: r = (b == 0) ? '1 : a / b;
            4'd6: if (b == 0) r = a;
                  else if (a == MIN64 && b == '1) r = '0;
                  else begin sq = sa % sb; r = sq; end
            4'd7: r = (b == 0) ? a : a % b;
            4'd8: r = sext32(ua * ub);
            4'd9: if (ub == 0) r = '1;
                  else if (ua == 32'h8000_0000 && ub == '1) r = sext32(32'h8000_0000);
                  else begin wq = wa / wb; r = sext32(wq); end
            4'd10: r = (ub == 0) ? '1 : sext32(ua / ub);
            4'd11: if (ub == 0) r = sext32(ua);
                   else if (ua == 32'h8000_0000 && ub == '1) r = '0;
                   else begin wq = wa % wb; r = sext32(wq); end
            4'd12: r = (ub == 0) ? sext32(ua) : sext32(ua % ub);
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef YSYX_22040931_MDU_SPECIAL_BYPASS_EN
    function automatic logic special_case(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return (a == 0) || (b == 0);
            4'd8:                   return (a[31:0] == 0) || (b[31:0] == 0);
            4'd4, 4'd6:             return (b == 0) || (a == MIN64 && b == '1);
            4'd5, 4'd7:             return (b == 0);
            4'd9, 4'd11:            return (b[31:0] == 0) || (a[31:0] == 32'h8000_0000 && b[31:0] == '1);
            4'd10, 4'd12:           return (b[31:0] == 0);
            default:                return 1'b0;
        endcase
    endfunction
`endif

    // Cycle (handshake = cycle 0) in which out_valid must first appear
    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = (op >= 4'd8 && op <= 4'd12) ? 34 : 66;
`ifdef YSYX_22040931_MDU_SPECIAL_BYPASS_EN
        if (special_case(op, a, b)) n = 2;
`endif
        return n;
    endfunction

    function automatic logic [63:0] rnd_opnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = MIN64;
            3: v = sext32($urandom);
            4: v = {v[63:32], 32'h8000_0000};
            5: v = 64'($urandom_range(0, 20));
            6: v = {32'd0, v[31:0]};
            default: ;
        endcase
        return v;
    endfunction

    // Issue one op, time its latency, check result and handshake, optionally stall
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input string tag);
        logic [63:0] exp;
        int          cyc;
        exp       = ref_mdu(op, a, b);
        out_ready = (hold == 0);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat(op, a, b)));
        check({tag, "_data"}, out_data, exp);
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            check({tag, "_hold_data"}, out_data, exp);
            check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_busy"}, 64'(in_ready), 64'd0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_src1   = '0;
        in_src2   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(OP_MUL,   64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, "mul_3_m5");
        run_op(OP_MULHU, '1, '1, 0, "mulhu_ones");
        run_op(OP_MULH,  '1, '1, 0, "mulh_ones");
        run_op(OP_DIV,   MIN64, '1, 0, "div_ovf");
        run_op(OP_REM,   MIN64, '1, 0, "rem_ovf");
        run_op(OP_DIVU,  64'd7, 64'd0, 0, "divu_zero");
        run_op(OP_REMU,  64'd7, 64'd0, 0, "remu_zero");
        run_op(OP_REMW,  64'h0000_0000_8000_0000, 64'd0, 0, "remw_zero");
        run_op(OP_DIVW,  64'h0000_0001_FFFF_FFF6, 64'd3, 5, "divw_hold");
        run_op(OP_MULHSU, '1, '1, 0, "mulhsu");
        run_op(4'd14,    64'd5, 64'd6, 0, "illegal");

        // Flush an in-flight DIV in cycle 10
        in_valid = 1'b1; in_op = OP_DIV; in_src1 = 64'd1000; in_src2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 64'(in_ready), 64'd1);
        check("flush_novld", 64'(out_valid), 64'd0);
        run_op(OP_DIVU, 64'd100, 64'd7, 0, "divu_after_flush");

        // A request presented together with flush is dropped
        in_valid = 1'b1; flush = 1'b1; in_op = OP_MUL; in_src1 = 64'd2; in_src2 = 64'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_reject", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of CALC
        in_valid = 1'b1; in_op = OP_DIV; in_src1 = 64'd1000; in_src2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rstmid_ready", 64'(in_ready), 64'd1);
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(OP_DIVU, 64'd100, 64'd7, 0, "divu_after_rst");

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [63:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = rnd_opnd();
            b  = rnd_opnd();
            run_op(op, a, b, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
